id_imm_ctrl: RTL and testbench

ID_IMM_CTRL -- requirements
Module: id_imm_ctrl

---
 rtl/id_imm_ctrl_if.sv | 43 ++++
 rtl/id_imm_ctrl.sv | 120 ++++++++++++
 tb/tb_id_imm_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/id_imm_ctrl_if.sv
// ---------------------------------------------------------------------------
// id_imm_ctrl_if
// Bundles the IF/ID input handshake, the immediate-generator side channel and
// the ID/EX output register of id_imm_ctrl.
//   slave  modport : the id_imm_ctrl block itself
//   master modport : the surrounding pipeline / immediate generator / bench
// Signals:
//   in_valid, in_instr[31:0], in_pc[31:0], in_ready  - IF/ID handshake
//   flush                                            - branch redirect
//   imm_src[1:0], imm_instr[31:0], imm_ext[31:0]     - immediate generator
//   out_valid, out_ready, out_pc, out_imm, out_rd,
//   out_illegal                                      - ID/EX register
//   issue_cnt[15:0]                                  - consumed-entry count
// ---------------------------------------------------------------------------
interface id_imm_ctrl_if;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        in_ready;
    logic        flush;
    logic [1:0]  imm_src;
    logic [31:0] imm_instr;
    logic [31:0] imm_ext;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_illegal;
    logic [15:0] issue_cnt;

    modport slave (
        input  in_valid, in_instr, in_pc, flush, imm_ext, out_ready,
        output in_ready, imm_src, imm_instr, out_valid, out_pc, out_imm,
               out_rd, out_illegal, issue_cnt
    );

    modport master (
        output in_valid, in_instr, in_pc, flush, imm_ext, out_ready,
        input  in_ready, imm_src, imm_instr, out_valid, out_pc, out_imm,
               out_rd, out_illegal, issue_cnt
    );
endinterface

// File: rtl/id_imm_ctrl.sv
// ---------------------------------------------------------------------------
// id_imm_ctrl
// Decode-stage immediate control: selects the immediate type for an external
// immediate generator, forms the final immediate (generator result, locally
// built U-type value, or zero) and holds it in a one-entry ID/EX register
// with a valid/ready handshake that sustains one instruction per cycle.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - id_imm_ctrl_if.slave (handshake, generator channel, ID/EX outputs)
// ---------------------------------------------------------------------------
module id_imm_ctrl (
    input  logic          clk,
    input  logic          rst,
    id_imm_ctrl_if.slave  bus
);

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    // The state bit is the output valid flag itself.
    logic [0:0]  state;
    logic [1:0]  imm_src_c;
    logic [31:0] imm_final;
    logic        illegal_c;
    logic        accept;
    logic        consume;
    logic        in_ready_c;

    // NOTE: every signal assigned in always_comb gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    always_comb begin
        imm_src_c = 2'b00;
        imm_final = 32'b0;
        illegal_c = 1'b0;
        unique case (bus.in_instr[6:0])
            OP_IMM, OP_LOAD, OP_JALR: begin
                imm_src_c = 2'b00;
                imm_final = bus.imm_ext;
            end
            OP_STORE: begin
                imm_src_c = 2'b01;
                imm_final = bus.imm_ext;
            end
            OP_BRANCH: begin
                imm_src_c = 2'b10;
                imm_final = bus.imm_ext;
            end
            OP_JAL: begin
                imm_src_c = 2'b11;
                imm_final = bus.imm_ext;
            end
            OP_LUI, OP_AUIPC: begin
                // U-type is a plain shift; no need to route it through the generator.
                imm_final = {bus.in_instr[31:12], 12'b0};
            end
            OP_REG: begin
                imm_final = 32'b0;
            end
            default: begin
                illegal_c = 1'b1;
                imm_final = 32'b0;
            end
        endcase
    end

    assign in_ready_c = ((state == EMPTY) || bus.out_ready) && !bus.flush;
    assign accept     = bus.in_valid && in_ready_c;
    assign consume    = (state == FULL) && bus.out_ready;

    assign bus.in_ready  = in_ready_c;
    assign bus.imm_src   = imm_src_c;
    assign bus.imm_instr = bus.in_instr;
    assign bus.out_valid = (state == FULL);

    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= EMPTY;
            bus.out_pc      <= 32'b0;
            bus.out_imm     <= 32'b0;
            bus.out_rd      <= 5'b0;
            bus.out_illegal <= 1'b0;
            bus.issue_cnt   <= 16'b0;
        end else begin
            // A consume in a flush cycle still left the stage, so it counts.
            if (consume) begin
                bus.issue_cnt <= bus.issue_cnt + 16'd1;
            end

            if (bus.flush) begin
                state <= EMPTY;
            end else if (accept) begin
                state <= FULL;
            end else if (consume) begin
                state <= EMPTY;
            end

            // Loading only on accept keeps idle/X inputs out of the register.
            if (accept) begin
                bus.out_pc      <= bus.in_pc;
                bus.out_imm     <= imm_final;
                bus.out_rd      <= bus.in_instr[11:7];
                bus.out_illegal <= illegal_c;
            end
        end
    end

endmodule

// File: tb/tb_id_imm_ctrl.sv
module tb_id_imm_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_imm_ctrl_if bus ();

    id_imm_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int n_asserts = 0;
    int n_fails   = 0;

    // Immediate generator stand-in: standard RISC-V formats selected by imm_src.
    function automatic logic [31:0] gen_imm(input logic [31:0] i, input logic [1:0] s);
        case (s)
            2'b00:   return {{20{i[31]}}, i[31:20]};
            2'b01:   return {{20{i[31]}}, i[31:25], i[11:7]};
            2'b10:   return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            default: return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        endcase
    endfunction
    assign bus.imm_ext = gen_imm(bus.imm_instr, bus.imm_src);

    // ---------------- reference model (opcode-level semantics) -------------
    function automatic logic [1:0] ref_src(input logic [31:0] i);
        case (i[6:0])
            7'h23:   return 2'b01;
            7'h63:   return 2'b10;
            7'h6F:   return 2'b11;
            default: return 2'b00;
        endcase
    endfunction

    function automatic bit ref_ill(input logic [31:0] i);
        case (i[6:0])
            7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F, 7'h37, 7'h17, 7'h33: return 1'b0;
            default: return 1'b1;
        endcase
    endfunction

    // Immediate value as the ISA defines it, using signed arithmetic.
    function automatic logic [31:0] ref_imm(input logic [31:0] i);
        int v;
        case (i[6:0])
            7'h13, 7'h03, 7'h67: v = $signed(i) >>> 20;
            7'h23: v = ($signed(i) >>> 25) * 32 + int'(i[11:7]);
            7'h63: v = ($signed(i) >>> 31) * 4096 + int'(i[7]) * 2048
                       + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            7'h6F: v = ($signed(i) >>> 31) * (1 << 20) + int'(i[19:12]) * 4096
                       + int'(i[20]) * 2048 + int'(i[30:21]) * 2;
            7'h37, 7'h17: v = int'(i & 32'hFFFF_F000);
            default: v = 0;
        endcase
        return 32'(v);
    endfunction

    bit          m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rd;
    bit          m_ill;
    int unsigned m_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check combinational outputs, clock,
    // advance the model, check registered outputs.
    task automatic step(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl, input logic rs, input bit chk);
        bit exp_rdy, acc, cons;
        bus.in_valid  = v;
        bus.in_instr  = instr;
        bus.in_pc     = pc;
        bus.out_ready = ordy;
        bus.flush     = fl;
        rst           = rs;
        #1;
        exp_rdy = (!m_valid || ordy) && !fl;
        acc     = v && exp_rdy;
        cons    = m_valid && ordy;
        if (chk) begin
            check("in_ready",  32'(bus.in_ready), 32'(exp_rdy));
            check("imm_src",   32'(bus.imm_src),  32'(ref_src(instr)));
            check("imm_instr", bus.imm_instr,     instr);
        end
        @(posedge clk);
        #1;
        if (rs) begin
            m_valid = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_ill = 0; m_cnt = 0;
        end else begin
            if (cons) m_cnt = (m_cnt + 1) % 65536;
            if (acc) begin
                m_pc  = pc;
                m_imm = ref_imm(instr);
                m_rd  = instr[11:7];
                m_ill = ref_ill(instr);
            end
            if (fl)        m_valid = 0;
            else if (acc)  m_valid = 1;
            else if (cons) m_valid = 0;
        end
        if (chk) begin
            check("out_valid",   32'(bus.out_valid),   32'(m_valid));
            check("out_pc",      bus.out_pc,           m_pc);
            check("out_imm",     bus.out_imm,          m_imm);
            check("out_rd",      32'(bus.out_rd),      32'(m_rd));
            check("out_illegal", 32'(bus.out_illegal), 32'(m_ill));
            check("issue_cnt",   32'(bus.issue_cnt),   m_cnt);
        end
    endtask

    logic [6:0] ops [11] = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6F,
                            7'h37, 7'h17, 7'h33, 7'h7F, 7'h0B};

    initial begin
        logic [31:0] r;
        m_valid = 0; m_pc = 0; m_imm = 0; m_rd = 0; m_ill = 0; m_cnt = 0;
        bus.in_valid = 0; bus.in_instr = 0; bus.in_pc = 0;
        bus.out_ready = 0; bus.flush = 0; rst = 1;
        @(posedge clk); #1;

        // Reset state
        step(0, 32'h0, 32'h0, 0, 0, 1, 1);
        step(0, 32'h0, 32'h0, 0, 0, 0, 1);

        // addi x1,x0,-1
        step(1, 32'hFFF0_0093, 32'h0000_1000, 1, 0, 0, 1);
        check("addi_imm", bus.out_imm, 32'hFFFF_FFFF);
        check("addi_rd",  32'(bus.out_rd), 32'd1);
        step(0, 32'h0, 32'h0, 1, 0, 0, 1);
        check("addi_cnt", 32'(bus.issue_cnt), 32'd1);

        // lui / jal
        step(1, 32'h1234_52B7, 32'h0000_1004, 1, 0, 0, 1);
        check("lui_imm", bus.out_imm, 32'h1234_5000);
        check("lui_ill", 32'(bus.out_illegal), 32'd0);
        step(1, 32'h0080_006F, 32'h0000_1008, 1, 0, 0, 1);
        check("jal_imm", bus.out_imm, 32'h0000_0008);
        step(0, 32'h0, 32'h0, 1, 0, 0, 1);

        // Back-to-back 4 with a 3-cycle stall after the first
        rst = 1; step(0, 32'h0, 32'h0, 0, 0, 1, 0);
        step(1, 32'h0010_0093, 32'h0000_2000, 1, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            step(1, 32'h0020_0113, 32'h0000_2004, 0, 0, 0, 1);
            check("stall_pc", bus.out_pc, 32'h0000_2000);
        end
        step(1, 32'h0020_0113, 32'h0000_2004, 1, 0, 0, 1);
        check("b2b_pc2", bus.out_pc, 32'h0000_2004);
        step(1, 32'h0030_0193, 32'h0000_2008, 1, 0, 0, 1);
        check("b2b_pc3", bus.out_pc, 32'h0000_2008);
        step(1, 32'h0040_0213, 32'h0000_200C, 1, 0, 0, 1);
        check("b2b_pc4", bus.out_pc, 32'h0000_200C);
        step(0, 32'h0, 32'h0, 1, 0, 0, 1);
        check("b2b_cnt", 32'(bus.issue_cnt), 32'd4);

        // Flush while FULL: once stalled (no count), once consuming (counts)
        step(1, 32'h0000_2083, 32'h0000_3000, 0, 0, 0, 1);
        step(1, 32'h0000_20A3, 32'h0000_3004, 0, 1, 0, 1);
        check("flush_cnt_hold", 32'(bus.issue_cnt), 32'd4);
        step(1, 32'h0000_2083, 32'h0000_3008, 0, 0, 0, 1);
        step(1, 32'h0000_20A3, 32'h0000_300C, 1, 1, 0, 1);
        check("flush_cnt_inc", 32'(bus.issue_cnt), 32'd5);

        // Illegal opcode and issue_cnt wrap
        rst = 1; step(0, 32'h0, 32'h0, 0, 0, 1, 0);
        step(1, 32'hABCD_EF7F, 32'h0000_4000, 0, 0, 0, 1);
        check("ill_flag", 32'(bus.out_illegal), 32'd1);
        check("ill_imm",  bus.out_imm, 32'h0);
        step(1, 32'hABCD_EF7F, 32'h0000_4000, 1, 0, 0, 0);
        for (int k = 0; k < 65533; k++)
            step(1, 32'h0000_0033, 32'h0000_4004, 1, 0, 0, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 1);
        check("cnt_ffff", 32'(bus.issue_cnt), 32'hFFFF);
        step(1, 32'h0000_0033, 32'h0000_4008, 1, 0, 0, 1);
        step(0, 32'h0, 32'h0, 1, 0, 0, 1);
        check("cnt_wrap", 32'(bus.issue_cnt), 32'h0);

        // Reset while FULL, stalled, flushing
        step(1, 32'h1234_52B7, 32'h0000_5000, 0, 0, 0, 1);
        step(1, 32'h0000_0013, 32'h0000_5004, 0, 1, 1, 1);
        check("rst_valid", 32'(bus.out_valid), 32'd0);
        step(0, 32'h0, 32'h0, 0, 0, 0, 1);
        check("rst_rdy", 32'(bus.in_ready), 32'd1);

        // Randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            r = $urandom;
            r[6:0] = ops[$urandom_range(0, 10)];
            step(1'($urandom_range(0, 3) != 0), r, $urandom,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
                 1'($urandom_range(0, 63) == 0), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
